// File: rtl/sdram_arbit_if.sv
// ---------------------------------------------------------------------------
// sdram_arbit_if
// Bundle of signals between the SDRAM command arbiter and the engines it
// serves. This includes the init, auto-refresh, write-burst and read-burst
// engines, and the registered pad outputs.
//
//   init      : flag_init_end, init_cmd, init_addr              (to arbiter)
//   refresh   : ref_req, flag_ref_end, aref_cmd, aref_addr      (to arbiter)
//               ref_en                                          (from arbiter)
//   write     : wr_req, flag_wr_end, wr_cmd, wr_addr, wr_ba     (to arbiter)
//               wr_en                                           (from arbiter)
//   read      : rd_req, flag_rd_end, rd_cmd, rd_addr, rd_ba     (to arbiter)
//               rd_en                                           (from arbiter)
//   status    : ref_pending                                     (from arbiter)
//   pads      : sdram_cmd, sdram_addr, sdram_ba                 (from arbiter)
//
// Modports: slave = arbiter side, master = engine / pad side.
// ---------------------------------------------------------------------------
interface sdram_arbit_if #(
  parameter int ADDR_W = 12,
  parameter int BA_W   = 2
);
  logic              flag_init_end;
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;

  logic              ref_req;
  logic              flag_ref_end;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              ref_en;

  logic              wr_req;
  logic              flag_wr_end;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [BA_W-1:0]   wr_ba;
  logic              wr_en;

  logic              rd_req;
  logic              flag_rd_end;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [BA_W-1:0]   rd_ba;
  logic              rd_en;

  logic              ref_pending;
  logic [3:0]        sdram_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [BA_W-1:0]   sdram_ba;

  modport slave (
    input  flag_init_end, init_cmd, init_addr,
    input  ref_req, flag_ref_end, aref_cmd, aref_addr,
    input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_ba,
    input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_ba,
    output ref_en, wr_en, rd_en, ref_pending,
    output sdram_cmd, sdram_addr, sdram_ba
  );

  modport master (
    output flag_init_end, init_cmd, init_addr,
    output ref_req, flag_ref_end, aref_cmd, aref_addr,
    output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_ba,
    output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_ba,
    input  ref_en, wr_en, rd_en, ref_pending,
    input  sdram_cmd, sdram_addr, sdram_ba
  );
endinterface

// File: rtl/sdram_arbit.sv
// ---------------------------------------------------------------------------
// sdram_arbit
// Top-level command arbiter for the SDRAM controller. It steps through
// power-up init first. After that it shares the single command/address bus
// between the auto-refresh, write-burst and read-burst engines. Refresh has
// priority. Write and read alternate when both request. A one-cycle en pulse
// grants the bus. The arbiter muxes the owner's command/address/bank onto
// registered pad outputs.
//
// Ports:
//   sclk  : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : sdram_arbit_if.slave (engine handshakes + pad outputs)
// ---------------------------------------------------------------------------
module sdram_arbit #(
  parameter int         ADDR_W  = 12,
  parameter int         BA_W    = 2,
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input logic           sclk,
  input logic           reset,
  sdram_arbit_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } state_t;

  state_t            r_state;
  state_t            w_next;
  // Only ST_WRITE / ST_READ are ever stored; decides write/read ties.
  state_t            r_last_grant;

  logic [3:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [BA_W-1:0]   w_ba;
  logic              w_ref_en, w_wr_en, w_rd_en, w_pending;

  logic [3:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [BA_W-1:0]   r_ba;
  logic              r_ref_en, r_wr_en, r_rd_en, r_pending;

  // State register. A burst exit records which of write/read just finished.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge sclk) begin
    if (reset) begin
      r_state      <= ST_INIT;
      r_last_grant <= ST_READ;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_WRITE || r_state == ST_READ) && w_next == ST_IDLE)
        r_last_grant <= r_state;
    end
  end

  // Next-state logic. Every exit goes through IDLE, so grants are always
  // separated by at least one NOP cycle on the pads.
  // NOTE: w_next gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:  if (bus.flag_init_end) w_next = ST_IDLE;
      ST_IDLE: begin
        if (bus.ref_req)
          w_next = ST_AREF;
        else if (bus.wr_req && bus.rd_req)
          w_next = (r_last_grant == ST_WRITE) ? ST_READ : ST_WRITE;
        else if (bus.wr_req)
          w_next = ST_WRITE;
        else if (bus.rd_req)
          w_next = ST_READ;
      end
      ST_AREF:  if (bus.flag_ref_end) w_next = ST_IDLE;
      ST_WRITE: if (bus.flag_wr_end)  w_next = ST_IDLE;
      ST_READ:  if (bus.flag_rd_end)  w_next = ST_IDLE;
      default:  w_next = ST_INIT;
    endcase
  end

  // Output logic: the pad mux follows the current owner. Grant pulses are
  // raised only on the IDLE->owner transition. ref_pending looks at the next
  // state, so it is already low in the IDLE cycle after a burst ends.
  always_comb begin
    w_cmd     = CMD_NOP;
    w_addr    = '0;
    w_ba      = '0;
    case (r_state)
      ST_INIT: begin
        w_cmd  = bus.init_cmd;
        w_addr = bus.init_addr;
      end
      ST_AREF: begin
        w_cmd  = bus.aref_cmd;
        w_addr = bus.aref_addr;
      end
      ST_WRITE: begin
        w_cmd  = bus.wr_cmd;
        w_addr = bus.wr_addr;
        w_ba   = bus.wr_ba;
      end
      ST_READ: begin
        w_cmd  = bus.rd_cmd;
        w_addr = bus.rd_addr;
        w_ba   = bus.rd_ba;
      end
      default: ;
    endcase
    w_ref_en  = (r_state == ST_IDLE) && (w_next == ST_AREF);
    w_wr_en   = (r_state == ST_IDLE) && (w_next == ST_WRITE);
    w_rd_en   = (r_state == ST_IDLE) && (w_next == ST_READ);
    w_pending = bus.ref_req && (w_next == ST_WRITE || w_next == ST_READ);
  end

  // Pad and handshake output registers.
  always_ff @(posedge sclk) begin
    if (reset) begin
      r_cmd     <= CMD_NOP;
      r_addr    <= '0;
      r_ba      <= '0;
      r_ref_en  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_cmd     <= w_cmd;
      r_addr    <= w_addr;
      r_ba      <= w_ba;
      r_ref_en  <= w_ref_en;
      r_wr_en   <= w_wr_en;
      r_rd_en   <= w_rd_en;
      r_pending <= w_pending;
    end
  end

  assign bus.sdram_cmd   = r_cmd;
  assign bus.sdram_addr  = r_addr;
  assign bus.sdram_ba    = r_ba;
  assign bus.ref_en      = r_ref_en;
  assign bus.wr_en       = r_wr_en;
  assign bus.rd_en       = r_rd_en;
  assign bus.ref_pending = r_pending;

endmodule

// File: tb/tb_sdram_arbit.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbit
// Self-checking bench for sdram_arbit. A behavioural model of bus ownership
// predicts every registered output. It is compared on each falling edge, and
// directed scenarios add literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_sdram_arbit;
  localparam int         ADDR_W = 12;
  localparam int         BA_W   = 2;
  localparam logic [3:0] NOP    = 4'b0111;

  localparam int G_NONE = 0;
  localparam int G_REF  = 1;
  localparam int G_WR   = 2;
  localparam int G_RD   = 3;

  logic sclk  = 1'b0;
  logic reset = 1'b1;

  sdram_arbit_if #(.ADDR_W(ADDR_W), .BA_W(BA_W)) bus ();

  sdram_arbit #(.ADDR_W(ADDR_W), .BA_W(BA_W), .CMD_NOP(NOP)) dut (
    .sclk  (sclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner of the bus, plus whether the last finished burst was a write.
  typedef enum {M_INIT, M_IDLE, M_REF, M_WR, M_RD} owner_t;
  owner_t            m_owner;
  bit                m_wr_last;
  bit                m_valid = 1'b0;
  logic [3:0]        e_cmd;
  logic [ADDR_W-1:0] e_addr;
  logic [BA_W-1:0]   e_ba;
  logic              e_ref_en, e_wr_en, e_rd_en, e_pend;

  always @(posedge sclk) begin
    if (reset) begin
      m_valid   = 1'b1;
      m_owner   = M_INIT;
      m_wr_last = 1'b0;
      e_cmd = NOP; e_addr = '0; e_ba = '0;
      e_ref_en = 1'b0; e_wr_en = 1'b0; e_rd_en = 1'b0; e_pend = 1'b0;
    end else if (m_valid) begin
      // Pads carry what the current owner presents this cycle.
      e_cmd = NOP; e_addr = '0; e_ba = '0;
      if (m_owner == M_INIT) begin e_cmd = bus.init_cmd; e_addr = bus.init_addr; end
      if (m_owner == M_REF)  begin e_cmd = bus.aref_cmd; e_addr = bus.aref_addr; end
      if (m_owner == M_WR)   begin e_cmd = bus.wr_cmd; e_addr = bus.wr_addr; e_ba = bus.wr_ba; end
      if (m_owner == M_RD)   begin e_cmd = bus.rd_cmd; e_addr = bus.rd_addr; e_ba = bus.rd_ba; end
      e_ref_en = 1'b0; e_wr_en = 1'b0; e_rd_en = 1'b0;
      // Ownership change: refresh first, write wins unless both want the
      // bus and write went last; owners release only on their own flag.
      if (m_owner == M_INIT && bus.flag_init_end) m_owner = M_IDLE;
      else if (m_owner == M_IDLE) begin
        if (bus.ref_req) begin m_owner = M_REF; e_ref_en = 1'b1; end
        else if (bus.wr_req && !(bus.rd_req && m_wr_last)) begin
          m_owner = M_WR; e_wr_en = 1'b1;
        end else if (bus.rd_req) begin m_owner = M_RD; e_rd_en = 1'b1; end
      end
      else if (m_owner == M_REF && bus.flag_ref_end) m_owner = M_IDLE;
      else if (m_owner == M_WR && bus.flag_wr_end) begin m_owner = M_IDLE; m_wr_last = 1'b1; end
      else if (m_owner == M_RD && bus.flag_rd_end) begin m_owner = M_IDLE; m_wr_last = 1'b0; end
      e_pend = bus.ref_req && (m_owner == M_WR || m_owner == M_RD);
    end
  end

  // Compare process: every cycle once the model has seen reset.
  always @(negedge sclk) begin
    if (m_valid) begin
      check("cmd",     32'(bus.sdram_cmd),   32'(e_cmd));
      check("addr",    32'(bus.sdram_addr),  32'(e_addr));
      check("ba",      32'(bus.sdram_ba),    32'(e_ba));
      check("ref_en",  32'(bus.ref_en),      32'(e_ref_en));
      check("wr_en",   32'(bus.wr_en),       32'(e_wr_en));
      check("rd_en",   32'(bus.rd_en),       32'(e_rd_en));
      check("pending", 32'(bus.ref_pending), 32'(e_pend));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge sclk);
    #2;
  endtask

  // Steps until one grant pulse appears (bounded); n = cycles waited.
  task automatic wait_grant(output int g, output int n);
    g = G_NONE;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (bus.wr_en)       g = G_WR;
      else if (bus.rd_en)  g = G_RD;
      else if (bus.ref_en) g = G_REF;
      if (g != G_NONE) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: no en pulse within 8 cycles at %0t", $time);
    end
  endtask

  int g, n;
  int exp_order[3] = '{G_WR, G_RD, G_WR};

  initial begin
    bus.flag_init_end = 0; bus.init_cmd = NOP; bus.init_addr = '0;
    bus.ref_req = 0; bus.flag_ref_end = 0; bus.aref_cmd = NOP; bus.aref_addr = '0;
    bus.wr_req = 0; bus.flag_wr_end = 0; bus.wr_cmd = NOP; bus.wr_addr = '0; bus.wr_ba = '0;
    bus.rd_req = 0; bus.flag_rd_end = 0; bus.rd_cmd = NOP; bus.rd_addr = '0; bus.rd_ba = '0;

    // Reset state
    repeat (3) step();
    check("rst_cmd",  32'(bus.sdram_cmd), 32'h7);
    check("rst_addr", 32'(bus.sdram_addr), 32'h0);
    check("rst_en",   32'({bus.ref_en, bus.wr_en, bus.rd_en, bus.ref_pending}), 32'h0);

    // Init handoff; a refresh request during init is ignored
    reset = 0;
    bus.init_cmd = 4'b0010; bus.init_addr = 12'h400; bus.ref_req = 1;
    step();
    check("init_cmd",  32'(bus.sdram_cmd), 32'h2);
    check("init_addr", 32'(bus.sdram_addr), 32'h400);
    step();
    check("init_ignore_ref", 32'(bus.ref_en), 32'h0);
    bus.ref_req = 0;
    bus.flag_init_end = 1;
    step();
    bus.flag_init_end = 0;
    step();
    check("idle_nop", 32'(bus.sdram_cmd), 32'h7);

    // Refresh
    bus.aref_cmd = 4'b0001; bus.aref_addr = 12'h123; bus.ref_req = 1;
    step();
    check("ref_en_pulse", 32'(bus.ref_en), 32'h1);
    bus.ref_req = 0;
    step();
    check("ref_en_drop", 32'(bus.ref_en), 32'h0);
    check("aref_cmd",    32'(bus.sdram_cmd), 32'h1);
    check("aref_addr",   32'(bus.sdram_addr), 32'h123);
    bus.flag_ref_end = 1;
    step();
    bus.flag_ref_end = 0;
    step();
    check("ref_exit_nop", 32'(bus.sdram_cmd), 32'h7);

    // Round-robin with both requests held, plus a stray read end flag
    bus.wr_cmd = 4'b0100; bus.wr_addr = 12'h0A5; bus.wr_ba = 2'b01;
    bus.rd_cmd = 4'b0101; bus.rd_addr = 12'h3C0; bus.rd_ba = 2'b10;
    bus.wr_req = 1; bus.rd_req = 1;
    for (int k = 0; k < 3; k++) begin
      wait_grant(g, n);
      check($sformatf("rr_order%0d", k), 32'(g), 32'(exp_order[k]));
      check($sformatf("rr_gap%0d", k), 32'(n), 32'd1);
      check($sformatf("rr_grant_nop%0d", k), 32'(bus.sdram_cmd), 32'h7);
      step();
      if (k == 0) begin
        bus.flag_rd_end = 1;
        step();
        bus.flag_rd_end = 0;
        check("stray_cmd",  32'(bus.sdram_cmd), 32'h4);
        check("stray_addr", 32'(bus.sdram_addr), 32'h0A5);
        check("stray_ba",   32'(bus.sdram_ba), 32'h1);
      end
      if (k == 2) begin bus.wr_req = 0; bus.rd_req = 0; end
      if (g == G_WR) bus.flag_wr_end = 1; else bus.flag_rd_end = 1;
      step();
      bus.flag_wr_end = 0; bus.flag_rd_end = 0;
    end

    // Refresh arriving during a write
    bus.wr_req = 1;
    wait_grant(g, n);
    check("rw_grant", 32'(g), 32'(G_WR));
    step();
    bus.ref_req = 1; bus.rd_req = 1;
    step();
    check("pending_set", 32'(bus.ref_pending), 32'h1);
    check("model_pending", 32'(e_pend), 32'h1);
    step();
    check("no_preempt", 32'(bus.sdram_cmd), 32'h4);
    bus.flag_wr_end = 1;
    step();
    bus.flag_wr_end = 0; bus.wr_req = 0;
    check("pending_clr", 32'(bus.ref_pending), 32'h0);
    step();
    check("ref_beats_rd", 32'({bus.ref_en, bus.rd_en}), 32'h2);
    bus.ref_req = 0;
    step();
    bus.flag_ref_end = 1;
    step();
    bus.flag_ref_end = 0;
    wait_grant(g, n);
    check("rd_after_ref", 32'(g), 32'(G_RD));

    // Reset in the middle of a read
    step();
    check("rd_cmd",  32'(bus.sdram_cmd), 32'h5);
    check("rd_addr", 32'(bus.sdram_addr), 32'h3C0);
    check("rd_ba",   32'(bus.sdram_ba), 32'h2);
    reset = 1;
    step();
    reset = 0;
    check("mid_rst_pads", 32'({bus.sdram_cmd, bus.sdram_addr, bus.sdram_ba}), 32'({4'b0111, 14'h0}));
    check("mid_rst_en",   32'({bus.ref_en, bus.wr_en, bus.rd_en, bus.ref_pending}), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst_rd_en%0d", i), 32'(bus.rd_en), 32'h0);
      check($sformatf("post_rst_init%0d", i), 32'(bus.sdram_cmd), 32'h2);
    end
    bus.flag_init_end = 1;
    step();
    bus.flag_init_end = 0;
    wait_grant(g, n);
    check("rd_after_init", 32'(g), 32'(G_RD));
    bus.rd_req = 0;
    bus.flag_rd_end = 1;
    step();
    bus.flag_rd_end = 0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
